// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 640x480 timing constants for timing and drawing logic
package vga_pkg;

    // Default 640x480 timing, in pixels (horizontal) and lines (vertical).
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_H_DISP = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 29;
    localparam int VGA_V_DISP = 480;
    localparam int VGA_V_FP   = 10;

    // Derived totals and first active column/row.
    localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BP + VGA_H_DISP + VGA_H_FP;
    localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BP + VGA_V_DISP + VGA_V_FP;
    localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position generator with inline /2 pixel strobe
//
// Ports:
//   clk          system clock (pixel rate is half of it)
//   rst_n        asynchronous active-low reset
//   pix_en       pixel strobe, high one clk in every two
//   h_cnt/v_cnt  raw horizontal/vertical counters
//   hsync/vsync  active-low sync pulses
//   visible      current pixel lies in the active area
//   x/y          active-area column/row, 0 outside the active area
//   line_start   high while h_cnt==0
//   frame_start  high while h_cnt==0 and v_cnt==0
//   frame_cnt    8-bit frame counter, only when VGA_FRAME_CNT_EN is defined
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int H_DISP = VGA_H_DISP,
    parameter int H_FP   = VGA_H_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP,
    parameter int V_DISP = VGA_V_DISP,
    parameter int V_FP   = VGA_V_FP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BP + H_DISP + H_FP - 1);
    localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BP + V_DISP + V_FP - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BP + H_DISP);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_DISP);

    logic       div;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       frame_wrap;
    logic       vis_nxt;
    logic [9:0] x_nxt;
    logic [9:0] y_nxt;

    // Next-state counters. The decoded outputs below are registered from
    // these, so they move on the same edge as h_cnt/v_cnt with no lag.
    always_comb begin
        h_nxt      = h_cnt;
        v_nxt      = v_cnt;
        frame_wrap = 1'b0;
        if (pix_en) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                if (v_cnt == V_LAST) begin
                    v_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = v_cnt + 10'd1;
                end
            end else begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        vis_nxt = (h_nxt >= H_ACT_START) && (h_nxt < H_ACT_END) &&
                  (v_nxt >= V_ACT_START) && (v_nxt < V_ACT_END);
        x_nxt   = vis_nxt ? (h_nxt - H_ACT_START) : 10'd0;
        y_nxt   = vis_nxt ? (v_nxt - V_ACT_START) : 10'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div         <= 1'b0;
            pix_en      <= 1'b0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            visible     <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            // pix_en follows the divider by one clk: first strobe lands on
            // the second edge after reset release.
            div         <= ~div;
            pix_en      <= div;
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= (h_nxt >= H_SYNC_END);
            vsync       <= (v_nxt >= V_SYNC_END);
            visible     <= vis_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            line_start  <= (h_nxt == 10'd0);
            frame_start <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // Steps on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed vector bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n  = 1'b0;
    logic       rst1_n = 1'b0;

    // Default-timing instance.
    logic       pe0, hs0, vs0, vis0, ls0, fs0;
    logic [9:0] h0, v0, x0, y0;
    // Tiny-timing instance: H 2+1+3+1=7, V 1+1+2+1=5, active h 3..5, v 2..3.
    logic       pe1, hs1, vs1, vis1, ls1, fs1;
    logic [9:0] h1, v1, x1, y1;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc0, fc1;
`endif

    vga_timing_gen u_dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pe0), .h_cnt(h0), .v_cnt(v0),
        .hsync(hs0), .vsync(vs0), .visible(vis0), .x(x0), .y(y0),
        .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing_gen #(
        .H_SYNC(2), .H_BP(1), .H_DISP(3), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_DISP(2), .V_FP(1)
    ) u_small (
        .clk(clk), .rst_n(rst1_n), .pix_en(pe1), .h_cnt(h1), .v_cnt(v1),
        .hsync(hs1), .vsync(vs1), .visible(vis1), .x(x1), .y(y1),
        .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Posedges since each instance left reset.
    int cyc0 = 0;
    int cyc1 = 0;
    always @(posedge clk) begin
        if (!rst_n) cyc0 <= 0; else cyc0 <= cyc0 + 1;
        if (!rst1_n) cyc1 <= 0; else cyc1 <= cyc1 + 1;
    end

    // hsync low samples across line 1 of the default instance
    // (pixel index n is first shown after posedge 2n+1).
    int hs_low = 0;
    int vs_low = 0;
    always @(negedge clk) begin
        if (rst_n && cyc0 >= 1601 && cyc0 <= 3200 && !hs0) hs_low++;
        if (rst1_n && cyc1 >= 71 && cyc1 <= 140 && !vs1) vs_low++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int sel, input int n);
        int guard = 0;
        while (((sel == 0) ? cyc0 : cyc1) < n && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        chk("edge_reached", (sel == 0) ? cyc0 : cyc1, n);
    endtask

    typedef struct {
        int   sel;
        int   h;
        int   v;
        logic hs;
        logic vs;
        logic vis;
        int   x;
        int   y;
        logic ls;
        logic fs;
    } vec_t;

    vec_t vecs[16];
    int   nvec;

    initial begin
        nvec = 0;
        //                 sel  h    v   hs   vs   vis   x    y   ls   fs
        vecs[nvec++] = '{0,  95,  0, 1'b0,1'b0,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0,  96,  0, 1'b1,1'b0,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0, 799, 10, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0,   0, 11, 1'b0,1'b1,1'b0,  0,   0, 1'b1,1'b0};
        vecs[nvec++] = '{0, 143, 31, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0, 144, 31, 1'b1,1'b1,1'b1,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0, 783, 31, 1'b1,1'b1,1'b1,639,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0, 784, 31, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{0, 144, 32, 1'b1,1'b1,1'b1,  0,   1, 1'b0,1'b0};
        vecs[nvec++] = '{0, 400, 32, 1'b1,1'b1,1'b1,256,   1, 1'b0,1'b0};
        // small instance, pixel index counts across frames (35 pixels/frame)
        vecs[nvec++] = '{1,   6,  4, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{1,   0,  5, 1'b0,1'b0,1'b0,  0,   0, 1'b1,1'b1};
        vecs[nvec++] = '{1,   2,  7, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{1,   3,  7, 1'b1,1'b1,1'b1,  0,   0, 1'b0,1'b0};
        vecs[nvec++] = '{1,   5,  8, 1'b1,1'b1,1'b1,  2,   1, 1'b0,1'b0};
        vecs[nvec++] = '{1,   3,  9, 1'b1,1'b1,1'b0,  0,   0, 1'b0,1'b0};

        // Reset held for 5 clk.
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_pix_en", pe0, 0);
        chk("rst_h_cnt", h0, 0);
        chk("rst_v_cnt", v0, 0);
        chk("rst_hsync", hs0, 0);
        chk("rst_vsync", vs0, 0);
        chk("rst_visible", vis0, 0);
        chk("rst_x", x0, 0);
        chk("rst_y", y0, 0);
        chk("rst_line_start", ls0, 1);
        chk("rst_frame_start", fs0, 1);
`ifdef VGA_FRAME_CNT_EN
        chk("rst_frame_cnt", fc0, 0);
`endif

        // Release: pix_en 0,1,0,1; first h increment on the third edge.
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("pix_en_edge%0d", k), pe0, (k % 2 == 0) ? 1 : 0);
            if (k == 2) chk("h_before_inc", h0, 0);
            if (k == 3) chk("h_first_inc", h0, 1);
        end

        for (int i = 0; i < nvec; i++) begin
            if (vecs[i].sel != 0) continue;
            wait_cyc(0, 2 * (vecs[i].v * 800 + vecs[i].h) + 1);
            chk($sformatf("v%0d_h_cnt", i), h0, vecs[i].h);
            chk($sformatf("v%0d_v_cnt", i), v0, vecs[i].v);
            chk($sformatf("v%0d_hsync", i), hs0, vecs[i].hs);
            chk($sformatf("v%0d_vsync", i), vs0, vecs[i].vs);
            chk($sformatf("v%0d_visible", i), vis0, vecs[i].vis);
            chk($sformatf("v%0d_x", i), x0, vecs[i].x);
            chk($sformatf("v%0d_y", i), y0, vecs[i].y);
            chk($sformatf("v%0d_line_start", i), ls0, vecs[i].ls);
            chk($sformatf("v%0d_frame_start", i), fs0, vecs[i].fs);
        end

        chk("hsync_low_clks", hs_low, 192);

        // Mid-frame reset at h=400, v=32: immediate return, no strobes.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_h_cnt", h0, 0);
        chk("mid_rst_v_cnt", v0, 0);
        chk("mid_rst_visible", vis0, 0);
        chk("mid_rst_line_start", ls0, 1);
        chk("mid_rst_frame_start", fs0, 1);
        begin
            int pe_seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (pe0) pe_seen++;
            end
            chk("mid_rst_pix_en_count", pe_seen, 0);
        end
        chk("mid_rst_h_held", h0, 0);

        // Small instance: frame wrap, vsync width, active-area edges.
        @(negedge clk);
        rst1_n = 1'b1;
        for (int i = 0; i < nvec; i++) begin
            if (vecs[i].sel != 1) continue;
            wait_cyc(1, 2 * (vecs[i].v * 7 + vecs[i].h) + 1);
`ifdef VGA_FRAME_CNT_EN
            if (vecs[i].v == 4 && vecs[i].h == 6) chk("fcnt_before_wrap", fc1, 0);
            if (vecs[i].v == 5 && vecs[i].h == 0) chk("fcnt_at_frame_start", fc1, 1);
`endif
            chk($sformatf("s%0d_h_cnt", i), h1, vecs[i].h % 7);
            chk($sformatf("s%0d_v_cnt", i), v1, vecs[i].v % 5);
            chk($sformatf("s%0d_hsync", i), hs1, vecs[i].hs);
            chk($sformatf("s%0d_vsync", i), vs1, vecs[i].vs);
            chk($sformatf("s%0d_visible", i), vis1, vecs[i].vis);
            chk($sformatf("s%0d_x", i), x1, vecs[i].x);
            chk($sformatf("s%0d_y", i), y1, vecs[i].y);
            chk($sformatf("s%0d_line_start", i), ls1, vecs[i].ls);
            chk($sformatf("s%0d_frame_start", i), fs1, vecs[i].fs);
        end
        wait_cyc(1, 141);
        chk("vsync_low_clks", vs_low, 14);

`ifdef VGA_FRAME_CNT_EN
        // 256 frames of 35 pixels: counter wraps back to 0 with frame_start.
        wait_cyc(1, 2 * (256 * 35 - 1) + 1);
        chk("fcnt_last", fc1, 255);
        chk("fcnt_last_fs", fs1, 0);
        wait_cyc(1, 2 * (256 * 35) + 1);
        chk("fcnt_wrap", fc1, 0);
        chk("fcnt_wrap_fs", fs1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
